// File: rtl/s08_spi_pkg.sv
// ============================================================================
// s08_spi_pkg : shared S08 peripheral bus definitions and SPI FSM encodings
// Rev 1.0
// ============================================================================
`default_nettype none

package s08_spi_pkg;

  localparam logic [1:0] c_ADDR_CTRL   = 2'd0;
  localparam logic [1:0] c_ADDR_STATUS = 2'd1;
  localparam logic [1:0] c_ADDR_DATA   = 2'd2;
  localparam logic [1:0] c_ADDR_DIV    = 2'd3;

  localparam int c_CTRL_EN   = 0;
  localparam int c_CTRL_CPOL = 1;
  localparam int c_CTRL_CPHA = 2;
  localparam int c_CTRL_LSBF = 3;
  localparam int c_CTRL_SS   = 7;
  localparam logic [7:0] c_CTRL_MASK = 8'h8F;

  localparam int c_ST_BUSY = 0;
  localparam int c_ST_RXF  = 1;
  localparam int c_ST_OVR  = 2;
  localparam int c_ST_WCOL = 3;

  localparam logic [1:0] c_S_IDLE = 2'd0;
  localparam logic [1:0] c_S_XFER = 2'd1;
  localparam logic [1:0] c_S_DONE = 2'd2;

  // Divider values below 2 would starve the miso synchronizer; clamp them.
  function automatic logic [7:0] eff_div(input logic [7:0] div);
    return (div < 8'd2) ? 8'd2 : div;
  endfunction

endpackage

`default_nettype wire

// File: rtl/s08_spi_bus_strobe.sv
// ============================================================================
// s08_bus_strobe : turns a multi-cycle CPU bus access into single-cycle events
// Rev 1.0
// ============================================================================
`default_nettype none

module s08_bus_strobe (
  input  logic clk,
  input  logic rst,
  input  logic i_sel,
  input  logic i_read,
  input  logic i_write,
  output logic o_wr_commit,
  output logic o_rd_end
);

  logic w_wr;
  logic w_rd;
  logic r_wr_q1;
  logic r_wr_q2;
  logic r_rd_q;
  logic r_wr_commit;
  logic r_rd_end;

  assign w_wr = i_sel & i_write;
  assign w_rd = i_sel & i_read;

  // Commit is delayed two cycles so write data has settled on the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_q1     <= 1'b0;
      r_wr_q2     <= 1'b0;
      r_wr_commit <= 1'b0;
      r_rd_q      <= 1'b0;
      r_rd_end    <= 1'b0;
    end else begin
      r_wr_q1     <= w_wr;
      r_wr_q2     <= r_wr_q1;
      r_wr_commit <= r_wr_q1 & ~r_wr_q2;
      r_rd_q      <= w_rd;
      r_rd_end    <= r_rd_q & ~w_rd;
    end
  end

  assign o_wr_commit = r_wr_commit;
  assign o_rd_end    = r_rd_end;

endmodule

`default_nettype wire

// File: rtl/s08_spi.sv
// ============================================================================
// s08_spi : memory-mapped SPI master on the MiniS08 CPU bus
// Rev 1.0
// ============================================================================
`default_nettype none

module s08_spi
  import s08_spi_pkg::*;
#(
  parameter logic [7:0] DIV_RESET = 8'd24,
  parameter logic       MOSI_IDLE = 1'b1
) (
  input  logic       clk50,
  input  logic       reset,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       sel,
  input  logic [1:0] addr,
  input  logic       Read,
  input  logic       Write,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  output logic       ss_n
);

  logic [1:0] r_state;
  logic [1:0] w_next_state;
  logic [7:0] r_ctrl;
  logic       r_rxf;
  logic       r_ovr;
  logic       r_wcol;
  logic [7:0] r_rxdata;
  logic [7:0] r_div;
  logic [7:0] r_shift;
  logic [7:0] r_cnt;
  logic [4:0] r_edges;
  logic       r_sclk;
  logic       r_mosi;
  logic       r_miso_s1;
  logic       r_miso_s2;
  logic [1:0] r_rd_addr;

  logic       w_wr_commit;
  logic       w_rd_end;
  logic       w_busy;
  logic       w_in_xfer;
  logic       w_in_done;
  logic       w_en;
  logic       w_cpol;
  logic       w_cpha;
  logic       w_lsbf;
  logic       w_wr_data;
  logic       w_load;
  logic       w_tick;
  logic       w_odd_edge;
  logic       w_sample;
  logic       w_shift_out;
  logic       w_rd_data_end;
  logic       w_rd_status_end;
  logic [7:0] w_status;

  s08_bus_strobe u_strobe (
    .clk         (clk50),
    .rst         (reset),
    .i_sel       (sel),
    .i_read      (Read),
    .i_write     (Write),
    .o_wr_commit (w_wr_commit),
    .o_rd_end    (w_rd_end)
  );

  assign w_en   = r_ctrl[c_CTRL_EN];
  assign w_cpol = r_ctrl[c_CTRL_CPOL];
  assign w_cpha = r_ctrl[c_CTRL_CPHA];
  assign w_lsbf = r_ctrl[c_CTRL_LSBF];

  assign w_wr_data       = w_wr_commit & (addr == c_ADDR_DATA);
  assign w_load          = (r_state == c_S_IDLE) & w_wr_data & w_en;
  assign w_rd_data_end   = w_rd_end & (r_rd_addr == c_ADDR_DATA);
  assign w_rd_status_end = w_rd_end & (r_rd_addr == c_ADDR_STATUS);

  // Edge number is r_edges+1, so an even count means the upcoming edge is odd.
  assign w_tick      = w_in_xfer & w_en & (r_cnt == 8'd0);
  assign w_odd_edge  = ~r_edges[0];
  assign w_sample    = w_tick & (w_cpha ? ~w_odd_edge : w_odd_edge);
  assign w_shift_out = w_tick & (w_cpha ? w_odd_edge : ~w_odd_edge);

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = c_S_IDLE;
    case (r_state)
      c_S_IDLE: w_next_state = w_load ? c_S_XFER : c_S_IDLE;
      c_S_XFER: begin
        if (!w_en) begin
          w_next_state = c_S_IDLE;
        end else if (w_tick && (r_edges == 5'd15)) begin
          w_next_state = c_S_DONE;
        end else begin
          w_next_state = c_S_XFER;
        end
      end
      c_S_DONE: w_next_state = c_S_IDLE;
      default:  w_next_state = c_S_IDLE;
    endcase
  end

  always_comb begin
    w_busy    = (r_state != c_S_IDLE);
    w_in_xfer = (r_state == c_S_XFER);
    w_in_done = (r_state == c_S_DONE);
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      r_miso_s1 <= 1'b0;
      r_miso_s2 <= 1'b0;
    end else begin
      r_miso_s1 <= miso;
      r_miso_s2 <= r_miso_s1;
    end
  end

  // Divider, sclk generation and shifter.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      r_shift <= 8'd0;
      r_cnt   <= 8'd0;
      r_edges <= 5'd0;
      r_sclk  <= 1'b0;
      r_mosi  <= MOSI_IDLE;
    end else begin
      case (r_state)
        c_S_IDLE: begin
          r_sclk <= w_cpol;
          if (w_load) begin
            r_shift <= din;
            r_cnt   <= eff_div(r_div);
            r_edges <= 5'd0;
            if (!w_cpha) begin
              r_mosi <= w_lsbf ? din[0] : din[7];
            end
          end
        end
        c_S_XFER: begin
          if (!w_en) begin
            r_sclk <= w_cpol;
            r_mosi <= MOSI_IDLE;
          end else if (w_tick) begin
            r_sclk  <= ~r_sclk;
            r_cnt   <= eff_div(r_div);
            r_edges <= r_edges + 5'd1;
            if (w_sample) begin
              r_shift <= w_lsbf ? {r_miso_s2, r_shift[7:1]} : {r_shift[6:0], r_miso_s2};
            end
            if (w_shift_out) begin
              r_mosi <= w_lsbf ? r_shift[0] : r_shift[7];
            end
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: begin
          r_sclk <= w_cpol;
          r_mosi <= MOSI_IDLE;
        end
      endcase
    end
  end

  // Register file; a completing byte takes priority over a coincident DATA read.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      r_ctrl    <= 8'd0;
      r_div     <= DIV_RESET;
      r_rxdata  <= 8'd0;
      r_rxf     <= 1'b0;
      r_ovr     <= 1'b0;
      r_wcol    <= 1'b0;
      r_rd_addr <= 2'd0;
    end else begin
      if (sel && Read) begin
        r_rd_addr <= addr;
      end
      if (w_wr_commit && (addr == c_ADDR_CTRL)) begin
        if (w_busy) begin
          r_ctrl[c_CTRL_EN] <= din[c_CTRL_EN];
          r_ctrl[c_CTRL_SS] <= din[c_CTRL_SS];
        end else begin
          r_ctrl <= din & c_CTRL_MASK;
        end
      end
      if (w_wr_commit && (addr == c_ADDR_DIV) && !w_busy) begin
        r_div <= din;
      end
      if (w_wr_data && w_busy) begin
        r_wcol <= 1'b1;
      end else if (w_rd_status_end) begin
        r_wcol <= 1'b0;
      end
      if (w_in_done) begin
        r_rxdata <= r_shift;
        r_rxf    <= 1'b1;
        r_ovr    <= w_rd_data_end ? 1'b0 : r_rxf;
      end else if (w_rd_data_end) begin
        r_rxf <= 1'b0;
        r_ovr <= 1'b0;
      end
    end
  end

  always_comb begin
    w_status              = 8'd0;
    w_status[c_ST_BUSY]   = w_busy;
    w_status[c_ST_RXF]    = r_rxf;
    w_status[c_ST_OVR]    = r_ovr;
    w_status[c_ST_WCOL]   = r_wcol;
  end

  always_comb begin
    dout = 8'd0;
    case (addr)
      c_ADDR_CTRL:   dout = r_ctrl & c_CTRL_MASK;
      c_ADDR_STATUS: dout = w_status;
      c_ADDR_DATA:   dout = r_rxdata;
      c_ADDR_DIV:    dout = r_div;
      default:       dout = 8'd0;
    endcase
  end

  assign sclk = r_sclk;
  assign mosi = r_mosi;
  assign ss_n = ~r_ctrl[c_CTRL_SS];

endmodule

`default_nettype wire
